// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ITEM_SIZE   = 8;
  localparam int DEF_BUFFER_SIZE = 8;

  // The count must also hold BUFFER_SIZE itself, so one bit more than clog2.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: round-robin after last_i, or a plain
// priority encoder when FIFO_ARB_FIXED_PRIORITY_EN is defined.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

`ifdef FIFO_ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    // Descending scan, so the lowest set index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req_i[cand]) idx_o = cand;
    end
    if (|req_i) grant_o[idx_o] = 1'b1;
  end
`else
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    // NOTE: every output and temporary gets a default first; otherwise a path
    // that leaves one unassigned infers a latch.
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers with a registered write
// and a local occupancy count. Optional: FIFO_ARB_FIXED_PRIORITY_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ITEM_SIZE   = DEF_ITEM_SIZE,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*ITEM_SIZE-1:0]       req_data,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               fifo_write_en,
  output logic [ITEM_SIZE-1:0]               fifo_data_in,
  input  logic                               fifo_read_en,
  output logic [occ_width(BUFFER_SIZE)-1:0]  occupancy,
  output logic                               full
);

  localparam int OCC_W = occ_width(BUFFER_SIZE);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 wr_en_q;
  logic [ITEM_SIZE-1:0] data_q, data_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 inflight;
  logic                 accept;
  logic                 read_consumed;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // The write register doubles as the in-flight flag: both are "accepted last cycle".
  assign inflight = wr_en_q;
  assign full     = (occ_q == OCC_W'(BUFFER_SIZE));
  assign grant    = (rst || full) ? '0 : pick_grant;
  assign accept   = |grant;

  // Items already inside the FIFO exclude the write still on its way in.
  assign read_consumed = fifo_read_en && (occ_q > OCC_W'(inflight));

  always_comb begin
    occ_d  = occ_q;
    last_d = last_q;
    data_d = data_q;
    case ({accept, read_consumed})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (accept) begin
      data_d = ITEM_SIZE'(req_data >> (int'(pick_idx) * ITEM_SIZE));
`ifndef FIFO_ARB_FIXED_PRIORITY_EN
      last_d = pick_idx;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
      occ_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      wr_en_q <= accept;
      data_q  <= data_d;
      occ_q   <= occ_d;
      last_q  <= last_d;
    end
  end

  assign fifo_write_en = wr_en_q;
  assign fifo_data_in  = data_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter; also builds with FIFO_ARB_FIXED_PRIORITY_EN.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] grant;
  logic         wen;
  logic [W-1:0] din;
  logic         rd;
  logic [3:0]   occ;
  logic         full;

  fifo_write_arbiter #(
    .NUM_REQ     (N),
    .ITEM_SIZE   (W),
    .BUFFER_SIZE (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .grant         (grant),
    .fifo_write_en (wen),
    .fifo_data_in  (din),
    .fifo_read_en  (rd),
    .occupancy     (occ),
    .full          (full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Independent reference state.
  int         m_last     = N - 1;
  int         m_occ      = 0;
  bit         m_inflight = 1'b0;
  logic [W-1:0] exp_q[$];

  // Values sampled in the most recent cycle, for directed checks.
  logic [N-1:0] g_seen;
  logic [3:0]   o_seen;
  logic         w_seen;
  logic [W-1:0] d_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_pick(input logic [N-1:0] r, input int last, output int idx);
    logic [N-1:0]   one = 4'b0001;
    logic [2*N-1:0] dbl;
    int             pos = 0;
    idx = 0;
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
    dbl = {4'b0000, r};
    for (int i = N - 1; i >= 0; i--) if (dbl[i]) pos = i;
    idx = pos;
`else
    dbl = {r, r} >> (last + 1);
    for (int i = N - 1; i >= 0; i--) if (dbl[i]) pos = i;
    idx = (last + 1 + pos) % N;
`endif
    return (r == '0) ? '0 : (one << idx);
  endfunction

  // One clock: inputs already driven at the falling edge; sample, compare, advance model.
  task automatic cycle();
    logic [N-1:0] eg;
    int           idx;
    bit           cons;
    #1;
    eg = m_pick(req, m_last, idx);
    if (rst || m_occ == D) eg = '0;
    g_seen = grant;
    o_seen = occ;
    w_seen = wen;
    d_seen = din;
    check("grant", grant, eg);
    check("occupancy", occ, m_occ);
    check("full", full, m_occ == D);
    check("write_en", wen, m_inflight);
    if (m_inflight) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: write seen with no expected item at %0t", $time);
      end else begin
        check("data_in", din, exp_q.pop_front());
      end
    end
    if (rst) begin
      m_last     = N - 1;
      m_occ      = 0;
      m_inflight = 1'b0;
      exp_q.delete();
    end else begin
      cons = rd && ((m_occ - int'(m_inflight)) > 0);
      if (eg != '0) begin
        exp_q.push_back(W'(req_data >> (idx * W)));
`ifndef FIFO_ARB_FIXED_PRIORITY_EN
        m_last = idx;
`endif
      end
      m_occ      = m_occ + ((eg != '0) ? 1 : 0) - (cons ? 1 : 0);
      m_inflight = (eg != '0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    rd  = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] one = 4'b0001;
    rst      = 1'b1;
    req      = '0;
    rd       = 1'b0;
    req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    check("rst_occ", o_seen, 0);
    check("rst_wen", w_seen, 0);
    check("rst_data", d_seen, 0);
    rst = 1'b0;

`ifndef FIFO_ARB_FIXED_PRIORITY_EN
    // Alternation between producers 0 and 2.
    req_data = 32'h0030_0010;
    req      = 4'b0101;
    cycle(); check("alt_g0", g_seen, 4'b0001);
    cycle(); check("alt_g1", g_seen, 4'b0100); check("alt_d0", d_seen, 8'h10);
    cycle(); check("alt_g2", g_seen, 4'b0001); check("alt_d1", d_seen, 8'h30);
    req = '0;
    cycle(); check("alt_d2", d_seen, 8'h10); check("alt_w2", w_seen, 1);
    do_reset();
`endif

    // Fill with no reads, then free one slot at the full boundary.
    req_data = 32'h4433_2211;
    req      = 4'b1111;
    for (int i = 0; i < D; i++) begin
      cycle();
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
      check("fill_grant", g_seen, 4'b0001);
`else
      check("fill_grant", g_seen, one << (i % N));
`endif
    end
    cycle();
    check("full_grant", g_seen, 0);
    check("full_occ", o_seen, 8);
    rd = 1'b1;
    cycle(); check("full_rd_grant", g_seen, 0);
    rd = 1'b0;
    cycle(); check("after_rd_occ", o_seen, 7); check("after_rd_grant", g_seen, 4'b0001);
    cycle(); check("refull_occ", o_seen, 8); check("refull_grant", g_seen, 0);
    do_reset();

    // Simultaneous accept and consumed read at occupancy 3.
    req_data = 32'h0000_00a5;
    req      = 4'b0001;
    repeat (3) cycle();
    req = '0;
    cycle();
    req = 4'b0001;
    rd  = 1'b1;
    cycle(); check("both_occ_before", o_seen, 3);
    req = '0;
    rd  = 1'b0;
    cycle(); check("both_occ_after", o_seen, 3);
    rd = 1'b1;
    repeat (5) cycle();
    check("drain_occ", o_seen, 0);
    cycle(); check("empty_read_occ", o_seen, 0);
    rd = 1'b0;
    do_reset();

    // Read while the only reserved slot is still in flight.
    req = 4'b0001;
    cycle();
    req = '0;
    rd  = 1'b1;
    cycle(); check("infl_occ", o_seen, 1); check("infl_wen", w_seen, 1);
    cycle(); check("infl_not_consumed", o_seen, 1);
    cycle(); check("infl_consumed", o_seen, 0);
    rd = 1'b0;

    // Reset in the middle of traffic.
    req = 4'b1111;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("midrst_wen", w_seen, 0);
    check("midrst_occ", o_seen, 0);
    check("midrst_grant", g_seen, 4'b0001);
    do_reset();

`ifdef FIFO_ARB_FIXED_PRIORITY_EN
    req_data = 32'h0000_2200;
    req      = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fixed_grant", g_seen, 4'b0010);
    end
    req = 4'b0100;
    cycle(); check("fixed_drop", g_seen, 4'b0100);
    req = '0;
    cycle();
`else
    // Sole requester keeps back-to-back grants.
    req_data = 32'h0000_2200;
    req      = 4'b0110;
    cycle(); check("rr_g0", g_seen, 4'b0010);
    cycle(); check("rr_g1", g_seen, 4'b0100);
    req = 4'b0100;
    cycle(); check("rr_solo0", g_seen, 4'b0100);
    cycle(); check("rr_solo1", g_seen, 4'b0100);
    req = '0;
    cycle();
`endif
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
